// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder_if                                                    |
// | Request/response bundle between a data-memory initiator and responder|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dmem_responder_if #(
  parameter int DMEM_ADDR_LEN = 8
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_we_i;
  logic [DMEM_ADDR_LEN-1:0] req_addr_i;
  logic [3:0]               req_wmask_i;
  logic [31:0]              req_wdata_i;
  logic                     resp_valid_o;
  logic                     resp_ready_i;
  logic [31:0]              resp_rdata_o;
  logic                     resp_we_o;
  logic                     resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wmask_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_we_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wmask_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_we_o, resp_err_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder                                                       |
// | Single-outstanding word memory with fixed latency and byte masks     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_responder #(
  parameter int DMEM_ADDR_LEN = 8,
  parameter int LATENCY       = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  dmem_responder_if.slave        bus,
  output logic [15:0]            load_cnt_o,
  output logic [15:0]            store_cnt_o
);

  localparam int c_IDX_W = DMEM_ADDR_LEN - 2;
  localparam int c_DEPTH = 1 << c_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_lat_cnt;
  logic               r_we;
  logic [c_IDX_W-1:0] r_word_idx;
  logic [3:0]         r_wmask;
  logic [31:0]        r_wdata;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_we;
  logic               r_resp_err;
  logic [15:0]        r_load_cnt;
  logic [15:0]        r_store_cnt;
  logic [31:0]        r_mem [c_DEPTH];

  logic               w_accept;
  logic               w_access;
  logic               w_resp_done;
  logic               w_mem_write;
  logic [31:0]        w_rd_word;
  wire  [31:0]        w_wr_word;
  logic               w_unused_addr;

  assign w_accept      = (r_state == IDLE) & bus.req_valid_i;
  assign w_access      = (r_state == ACCESS) & (r_lat_cnt == 2'd0);
  assign w_resp_done   = (r_state == RESP) & bus.resp_ready_i;
  assign w_mem_write   = w_access & r_we & (r_wmask != 4'b0000);
  assign w_rd_word     = r_mem[r_word_idx];
  assign w_unused_addr = ^bus.req_addr_i[1:0];

  // Unmasked lanes keep the stored byte, so the write is a whole-word update.
  generate
    for (genvar n = 0; n < 4; n++) begin : g_lane
      assign w_wr_word[8*n +: 8] = r_wmask[n] ? r_wdata[8*n +: 8] : w_rd_word[8*n +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid_i)    w_state_next = ACCESS;
      ACCESS:  if (r_lat_cnt == 2'd0)  w_state_next = RESP;
      RESP:    if (bus.resp_ready_i)   w_state_next = IDLE;
      default:                         w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lat_cnt    <= 2'd0;
      r_we         <= 1'b0;
      r_word_idx   <= '0;
      r_wmask      <= 4'b0000;
      r_wdata      <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_load_cnt   <= 16'h0;
      r_store_cnt  <= 16'h0;
    end else begin
      if (w_accept) begin
        r_we       <= bus.req_we_i;
        r_word_idx <= bus.req_addr_i[DMEM_ADDR_LEN-1:2];
        r_wmask    <= bus.req_wmask_i;
        r_wdata    <= bus.req_wdata_i;
        r_lat_cnt  <= 2'(LATENCY - 1);
      end else if ((r_state == ACCESS) && (r_lat_cnt != 2'd0)) begin
        r_lat_cnt  <= r_lat_cnt - 2'd1;
      end

      if (w_access) begin
        r_resp_rdata <= r_we ? 32'h0 : w_rd_word;
        r_resp_we    <= r_we;
        r_resp_err   <= r_we & (r_wmask == 4'b0000);
      end

      // Error responses still count as completed requests.
      if (w_resp_done) begin
        if (r_resp_we) begin
          if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'd1;
        end else begin
          if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'd1;
        end
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_write) begin
      r_mem[r_word_idx] <= w_wr_word;
    end
  end

  assign bus.req_ready_o  = (r_state == IDLE);
  assign bus.resp_valid_o = (r_state == RESP);
  assign bus.resp_rdata_o = r_resp_rdata;
  assign bus.resp_we_o    = r_resp_we;
  assign bus.resp_err_o   = r_resp_err;
  assign load_cnt_o       = r_load_cnt;
  assign store_cnt_o      = r_store_cnt;

endmodule
`default_nettype wire
